clock_ratio_detector: RTL
=========================

Name: clock_ratio_detector

Overview:
Receive-side companion to the clock divider. Samples a slow, divided or externally sourced clock (`divided_clock`) in the fast `input_clock` domain and synchronizes it. Detects its edges and measures its period and high time in `input_clock` cycles. Declares lock once the period is stable. Downstream image-pipeline logic uses the edge strobes as clock enables, and uses `period` / `locked` to confirm the expected division ratio.

Parameters:
COUNTER_WIDTH, 16, width of period/high-time counters and outputs.
LOCK_COUNT, 4, consecutive matching periods required to assert `locked` (min 1).
SYNC_STAGES, 2, synchronizer flops on `divided_clock` (min 2).

Ports:
input_clock  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  1 = measure; 0 = hold in IDLE.
divided_clock  in  1  asynchronous slow clock under measurement.
rise_strobe  out  1  one-cycle pulse per synchronized rising edge.
fall_strobe  out  1  one-cycle pulse per synchronized falling edge.
period  out  COUNTER_WIDTH  last measured rise-to-rise period, in input_clock cycles.
high_time  out  COUNTER_WIDTH  last measured rise-to-fall time, in input_clock cycles.
period_valid  out  1  one-cycle pulse when `period` updates.
locked  out  1  level; period stable.
timeout  out  1  sticky; no rising edge within 2^COUNTER_WIDTH-1 cycles.

Behaviour:
- Reset: all outputs 0; synchronizer and previous-sample flops 0; counters 0; match count 0; state IDLE.
- Synchronizer: SYNC_STAGES flops, then one previous-sample flop.
  - `rise_strobe` = sync & ~prev.
  - `fall_strobe` = ~sync & prev.
  - Strobes are active in every state except IDLE. Latency from a stable input change to the strobe is SYNC_STAGES+1 cycles.
- Counter `cnt`:
  - Cleared to 1 in the cycle of `rise_strobe`.
  - Otherwise increments each cycle.
  - Saturates at all-ones.
- States:
  - IDLE: entered on reset or `enable`=0 (from any state, next cycle). Clears `locked`, `timeout`, match count and `cnt`. Moves to ACQUIRE when `enable`=1.
  - ACQUIRE: waits for the first rise. On rise, `cnt` starts and the state moves to MEASURE; no period is reported.
  - MEASURE: on each rise:
    - `period` <= `cnt`; `period_valid` pulses.
    - If the new period equals the previous period, match count increments; otherwise match count = 0.
    - When match count reaches LOCK_COUNT, go to LOCKED and set `locked`=1.
  - LOCKED: on each rise, `period` updates and `period_valid` pulses. A mismatch clears `locked` and match count and returns to MEASURE.
- High time: on `fall_strobe` in MEASURE or LOCKED, `high_time` <= `cnt`.
- Timeout: if `cnt` saturates in MEASURE or LOCKED:
  - `timeout`=1 (sticky until IDLE or reset).
  - `locked`=0, match count=0.
  - State returns to ACQUIRE.
  - `period` and `high_time` hold their last values.
- Simultaneous events: rise and saturation in the same cycle are treated as a rise; no timeout.
- `reset` has priority over `enable`.
- Reset mid-measurement discards partial counts immediately.
- Width rule: a period > 2^COUNTER_WIDTH-2 is never reported; it yields a timeout.

Optional Feature:
Macro PERIOD_TOLERANCE_EN.
- Defined: "match" means |new − previous| ≤ 1. This absorbs ±1-cycle synchronizer jitter on asynchronous inputs.
- Not defined: "match" means exact equality.
- All other behaviour is identical in both builds.

Test Plan:
- Divided clock toggling every 3 cycles (period 6), `enable`=1 → `period`=6 and `high_time`=3 on each update; `locked`=1 after the 4th matching period; `rise_strobe` pulses every 6 cycles.
- Locked at period 6, input switched to period 10 → first `period`=10 with `locked` dropping in the same update cycle; relock after 4 further periods of 10.
- COUNTER_WIDTH=8, `divided_clock` held low after lock → `timeout`=1 at `cnt`=255; `locked`=0; `period` holds 6; state ACQUIRE; a later rise restarts measurement without clearing `timeout`.
- Alternating periods 7/8:
  - Without PERIOD_TOLERANCE_EN → `locked` never asserts.
  - With PERIOD_TOLERANCE_EN → `locked` after 4 periods.
- `reset` pulsed mid-period while locked → next cycle all outputs 0, state IDLE; with `enable`=1, the first `period_valid` occurs only after two further rises.
- `enable` deasserted while locked → `locked`, `timeout` cleared next cycle; no strobes while `enable`=0.

Source files
------------

// File: rtl/clock_ratio_detector.sv
// clock_ratio_detector: synchronizes a slow clock into the input_clock
// domain, emits edge strobes, measures period/high time and reports lock.
// Optional build macro: PERIOD_TOLERANCE_EN (period match within +/-1 cycle).
module clock_ratio_detector #(
  parameter int unsigned COUNTER_WIDTH = 16,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     input_clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     divided_clock,
  output logic                     rise_strobe,
  output logic                     fall_strobe,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic [COUNTER_WIDTH-1:0] high_time,
  output logic                     period_valid,
  output logic                     locked,
  output logic                     timeout
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = CNT_MAX - 1'b1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
  localparam logic [MW-1:0]            LOCK_N   = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_MEASURE, S_LOCKED} state_t;

  state_t                   state_q;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     prev_q;
  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic [COUNTER_WIDTH-1:0] period_q;
  logic [COUNTER_WIDTH-1:0] high_time_q;
  logic [MW-1:0]            match_q;
  logic                     rise_q, fall_q, period_valid_q, locked_q, timeout_q;

  logic                     sync_w, rise_w, fall_w, is_match;
  logic [COUNTER_WIDTH-1:0] cnt_inc_d, diff_d;
  logic [MW-1:0]            match_inc_d;

  assign sync_w = sync_q[SYNC_STAGES-1];
  assign rise_w = sync_w & ~prev_q;
  assign fall_w = ~sync_w & prev_q;

  // Saturating counter increment, match-count increment and period comparison
  always_comb begin
    cnt_inc_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    match_inc_d = match_q + 1'b1;
    diff_d      = (cnt_q >= period_q) ? (cnt_q - period_q) : (period_q - cnt_q);
`ifdef PERIOD_TOLERANCE_EN
    is_match    = (diff_d <= CNT_ONE);
`else
    is_match    = (diff_d == '0);
`endif
  end

  // Synchronizer, edge detection, measurement FSM and registered outputs.
  // Timeout fires on the edge where cnt would reach all-ones, so a rise
  // arriving at cnt = max-1 still reports and max itself is never reported.
  always_ff @(posedge input_clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      sync_q         <= '0;
      prev_q         <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      match_q        <= '0;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      sync_q         <= {sync_q[SYNC_STAGES-2:0], divided_clock};
      prev_q         <= sync_w;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      period_valid_q <= 1'b0;
      if (!enable) begin
        state_q   <= S_IDLE;
        locked_q  <= 1'b0;
        timeout_q <= 1'b0;
        match_q   <= '0;
        cnt_q     <= '0;
      end else begin
        rise_q <= (state_q != S_IDLE) && rise_w;
        fall_q <= (state_q != S_IDLE) && fall_w;
        unique case (state_q)
          S_IDLE: begin
            cnt_q     <= '0;
            match_q   <= '0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            state_q   <= S_ACQUIRE;
          end
          S_ACQUIRE: begin
            if (rise_w) begin
              cnt_q   <= CNT_ONE;
              state_q <= S_MEASURE;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          S_MEASURE, S_LOCKED: begin
            if (fall_w) high_time_q <= cnt_q;
            if (rise_w) begin
              cnt_q          <= CNT_ONE;
              period_q       <= cnt_q;
              period_valid_q <= 1'b1;
              if (!is_match) begin
                match_q  <= '0;
                locked_q <= 1'b0;
                state_q  <= S_MEASURE;
              end else if (state_q == S_MEASURE) begin
                match_q <= match_inc_d;
                if (match_inc_d == LOCK_N) begin
                  locked_q <= 1'b1;
                  state_q  <= S_LOCKED;
                end
              end
            end else if (cnt_q >= CNT_LAST) begin
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              match_q   <= '0;
              cnt_q     <= cnt_inc_d;
              state_q   <= S_ACQUIRE;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rise_strobe  = rise_q;
  assign fall_strobe  = fall_q;
  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule
